ps2_kbmat: RTL and testbench
============================

# ps2_kbmat

PS/2 keyboard front end that builds the 64-bit Z88 key matrix `kbmat`, which the blink consumes directly for its row/column keyboard reads and key-press interrupt. It receives PS/2 device-to-host frames and tracks make/break, `E0` extended and `E1` pause prefixes. Scan codes are translated to matrix positions through an external combinational map, and each mapped key's bit is set or cleared. This block sits directly upstream of the blink `kbmat` input.

## Interface
- `FILT_LEN`, default 4: number of consecutive equal synchronised samples required before the filtered `ps2_clk` changes.
- `TIMEOUT`, default 9830: `mck` cycles with no filtered `ps2_clk` falling edge (about 1 ms) before a partial frame is aborted.

- `mck` in 1: 9.83 MHz master clock. This is the block's only clock.
- `rin` in 1: reset, synchronous, active-high.
- `ps2_clk` in 1: PS/2 clock, asynchronous.
- `ps2_dat` in 1: PS/2 data, asynchronous.
- `map_idx` in 7: result from the external map. Bit 6 = valid; bits [5:0] = row*8+col.
- `map_code` out 8: scan code presented to the external map.
- `map_ext` out 1: the code presented on `map_code` was preceded by `E0`.
- `kbmat` out 64: key matrix. 1 = pressed. Bit n = row n/8, column n%8.
- `kbd_evt` out 1: one-cycle pulse when a `kbmat` bit is written.
- `rx_err` out 1: one-cycle pulse on parity, start, stop or timeout error.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_dat` each pass through a 2-flop synchroniser.
  - The synchronised clock then passes through the `FILT_LEN` glitch filter.
  - A bit strobe fires on each falling edge of the filtered clock.
  - Data is taken from the synchronised `ps2_dat` in the strobe cycle.
- **Frame FSM** (IDLE, DATA, PARITY, STOP)
  - IDLE: on a strobe with dat=0, go to DATA with bitcnt=0. A strobe with dat=1 is ignored.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: capture the parity bit; the frame requires odd parity over the 8 data bits plus parity. Go to STOP.
  - STOP: with dat=1 and correct parity, raise the internal `byte_valid` pulse. Otherwise pulse `rx_err`. Return to IDLE in both cases.
  - Timeout: in any state other than IDLE, a counter is cleared on every strobe. When it reaches `TIMEOUT`, the FSM returns to IDLE and pulses `rx_err`.
- **Decoder**, flags `brk`, `ext` and 3-bit `skip`
  - `skip` != 0: the byte is discarded and `skip` decrements.
  - `E1`: set `skip` = 7, which discards the pause sequence.
  - `E0`: set `ext`=1.
  - `F0`: set `brk`=1.
  - `00`, `AA`, `FF` with brk=0: clear all of `kbmat`; `kbd_evt` stays 0.
  - `FA`, `EE`, `FE` with brk=0: discard.
  - Any other byte: load `map_code`=byte and `map_ext`=ext, then enter LOOKUP for one cycle. In the next cycle, if `map_idx[6]`=1, write `kbmat[map_idx[5:0]]` = !brk and pulse `kbd_evt`. If `map_idx[6]`=0 the code is unmapped: no write and no pulse.
  - `brk` and `ext` clear after any byte that is not `E0`/`F0`.
  - Writing a bit to the value it already holds still pulses `kbd_evt`.
- **Error handling:** `rx_err` clears `brk`, `ext` and `skip`. `kbmat` is preserved.

## Timing
- **Reset:**
  - `kbmat`=0, `map_code`=0, `map_ext`=0, `kbd_evt`=0, `rx_err`=0.
  - FSM in IDLE; `brk`, `ext`, `skip` and the timeout counter all 0.
  - Filtered clock = 1.
  - Reset mid-frame drops the partial byte; reset in LOOKUP suppresses the write.
- **Edge delay:** from a `ps2_clk` pin fall to the strobe is 2 + `FILT_LEN` cycles, ±1.
- **Byte latency:**
  - Cycle T: `byte_valid` on the stop-bit strobe.
  - T+1: `map_code`/`map_ext` registered.
  - T+2: `kbmat` updated and `kbd_evt` high.
- `map_code` holds until the next mapped byte. The external map must settle within one cycle.
- PS/2 frames are at least 60 µs apart, so no byte arrives during LOOKUP. The decoder needs only one byte of capacity.
- A timeout that coincides with a strobe: the strobe wins and the counter clears.
- `rx_err` and `kbd_evt` are never high in the same cycle.

## Test plan
Bench map: code `1C`/ext0 → idx 0x6D (row 5, column 5); code `74`/ext1 → idx 0x43; all other codes → `00`.
- Reset, then idle lines → `kbmat`=0, no pulses, `map_code`=0.
- Send `1C`, then `F0 1C` → `kbmat[45]`=1 at T+2 with one `kbd_evt`, then 0 after the break with a second `kbd_evt`; `map_ext`=0 both times.
- Send `E0 74`, then `E0 F0 74` → `kbmat[3]` set then cleared, `map_ext`=1. A following plain `74` maps invalid → no write.
- Frame `1C` with a parity error → `rx_err` pulse, `kbmat` unchanged. Then `F0` followed by a bad stop bit, then `1C` → treated as make; `brk` was cleared by the error.
- Stop `ps2_clk` after 4 bits for `TIMEOUT`+10 cycles → `rx_err` at the timeout cycle. A following clean `1C` decodes correctly.
- Hold `kbmat[45]` pressed, send `E1 14 77 E1 F0 14 F0 77` → no change. Then `AA` → `kbmat`=0. Glitch pulses shorter than `FILT_LEN` on `ps2_clk` → no strobe.

Source files
------------

// File: rtl/ps2_kbmat.sv
// PS/2 keyboard receiver that maintains the 64-bit Z88 key matrix.
// Scan codes are resolved through an external map. Make/break, E0 and E1 prefixes are handled here.
//   state    | meaning
//   S_IDLE   | waiting for a start bit
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking the stop bit and the odd parity
module ps2_kbmat #(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 9830
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic [6:0]  map_idx,
    output logic [7:0]  map_code,
    output logic        map_ext,
    output logic [63:0] kbmat,
    output logic        kbd_evt,
    output logic        rx_err
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_q;
    logic [FW-1:0] r_filt_cnt;
    logic          w_strobe;

    state_t        r_state, w_next;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout, w_byte_valid, w_err;

    logic          r_brk, r_ext, r_lk_brk, r_lookup;
    logic [2:0]    r_skip;
    logic [7:0]    r_map_code;
    logic          r_map_ext;
    logic [63:0]   r_kbmat;
    logic          r_kbd_evt, r_rx_err;

    always_ff @(posedge mck) begin
        if (rin) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_q   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
            r_filt_q <= r_filt;
            // The filtered clock only follows after FILT_LEN consecutive differing samples.
            if (r_clk_s2 != r_filt) begin
                if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
                    r_filt     <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_strobe  = r_filt_q & ~r_filt;
    assign w_timeout = (r_state != S_IDLE) && !w_strobe && (r_to_cnt == TW'(TIMEOUT));

    always_comb begin
        w_next       = r_state;
        w_byte_valid = 1'b0;
        w_err        = 1'b0;
        if (w_timeout) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
        end else if (w_strobe) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_next = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP: begin
                    w_next = S_IDLE;
                    if (r_dat_s2 && (^{r_shift, r_par})) w_byte_valid = 1'b1;
                    else                                 w_err        = 1'b1;
                end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_strobe) begin
                case (r_state)
                    S_IDLE:   r_bitcnt <= '0;
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    S_PARITY: r_par <= r_dat_s2;
                    default:  r_par <= r_par;
                endcase
            end
            if (r_state == S_IDLE || w_strobe || w_timeout) r_to_cnt <= '0;
            else                                            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            r_skip     <= '0;
            r_lk_brk   <= 1'b0;
            r_lookup   <= 1'b0;
            r_map_code <= '0;
            r_map_ext  <= 1'b0;
            r_kbmat    <= '0;
            r_kbd_evt  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_err  <= w_err;
            r_kbd_evt <= 1'b0;
            if (r_lookup) begin
                r_lookup <= 1'b0;
                if (map_idx[6]) begin
                    r_kbmat[map_idx[5:0]] <= ~r_lk_brk;
                    r_kbd_evt             <= 1'b1;
                end
            end
            if (w_err) begin
                r_brk  <= 1'b0;
                r_ext  <= 1'b0;
                r_skip <= '0;
            end else if (w_byte_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 1'b1;
                end else if (r_shift == 8'hE1) begin
                    r_skip <= 3'd7;
                    r_brk  <= 1'b0;
                    r_ext  <= 1'b0;
                end else if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    // Keyboard self-test/reset codes wipe the matrix; command replies are dropped.
                    if (!r_brk && (r_shift == 8'h00 || r_shift == 8'hAA || r_shift == 8'hFF)) begin
                        r_kbmat <= '0;
                    end else if (!r_brk && (r_shift == 8'hFA || r_shift == 8'hEE || r_shift == 8'hFE)) begin
                        r_lookup <= 1'b0;
                    end else begin
                        r_map_code <= r_shift;
                        r_map_ext  <= r_ext;
                        r_lk_brk   <= r_brk;
                        r_lookup   <= 1'b1;
                    end
                end
            end
        end
    end

    assign map_code = r_map_code;
    assign map_ext  = r_map_ext;
    assign kbmat    = r_kbmat;
    assign kbd_evt  = r_kbd_evt;
    assign rx_err   = r_rx_err;

endmodule

// File: tb/tb_ps2_kbmat.sv
// Directed and randomized PS/2 frames checked against a byte-level model of the key matrix.
module tb_ps2_kbmat;
    localparam int FILT_LEN = 4;
    localparam int TIMEOUT  = 500;

    logic        mck = 1'b0;
    logic        rin = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [6:0]  map_idx;
    logic [7:0]  map_code;
    logic        map_ext;
    logic [63:0] kbmat;
    logic        kbd_evt;
    logic        rx_err;

    ps2_kbmat #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
        .mck(mck), .rin(rin), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .map_idx(map_idx), .map_code(map_code), .map_ext(map_ext),
        .kbmat(kbmat), .kbd_evt(kbd_evt), .rx_err(rx_err)
    );

    always #5 mck = ~mck;

    function automatic int bench_map(input logic [7:0] code, input logic ext);
        if (code == 8'h1C && !ext) return 45;
        if (code == 8'h74 && ext)  return 3;
        return -1;
    endfunction

    always_comb begin
        map_idx = 7'd0;
        if (bench_map(map_code, map_ext) >= 0) map_idx = {1'b1, 6'(bench_map(map_code, map_ext))};
    end

    int cyc = 0;
    int evt_cnt = 0, err_cnt = 0, both_cnt = 0, evt_cyc = 0, err_cyc = 0;
    int checks = 0, errors = 0;
    int last_fall = 0;

    always @(posedge mck) cyc++;
    always @(negedge mck) begin
        if (kbd_evt) begin evt_cnt++; evt_cyc = cyc; end
        if (rx_err)  begin err_cnt++; err_cyc = cyc; end
        if (kbd_evt && rx_err) both_cnt++;
    end

    // reference model state
    logic [63:0] mkb = '0;
    logic        mbrk = 1'b0, mext = 1'b0, mcext = 1'b0;
    logic [7:0]  mcode = '0;
    int          mskip = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge mck); #1; end
    endtask

    task automatic model_byte(input logic [7:0] b, output int evt);
        int idx;
        evt = 0;
        if (mskip > 0) begin
            mskip--;
        end else if (b == 8'hE1) begin
            mskip = 7; mbrk = 0; mext = 0;
        end else if (b == 8'hE0) begin
            mext = 1;
        end else if (b == 8'hF0) begin
            mbrk = 1;
        end else begin
            if (!mbrk && (b == 8'h00 || b == 8'hAA || b == 8'hFF)) begin
                mkb = '0;
            end else if (!mbrk && (b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
                evt = 0;
            end else begin
                mcode = b;
                mcext = mext;
                idx = bench_map(b, mext);
                if (idx >= 0) begin mkb[idx] = !mbrk; evt = 1; end
            end
            mbrk = 0; mext = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int h, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            tick(h);
            ps2_clk = 1'b0;
            last_fall = cyc;
            tick(h);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        tick(h);
    endtask

    task automatic send_check(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int h, input string tag);
        int e0, r0, eevt, eerr;
        e0 = evt_cnt; r0 = err_cnt;
        if (bad_par || bad_stop) begin
            mbrk = 0; mext = 0; mskip = 0; eevt = 0; eerr = 1;
        end else begin
            model_byte(b, eevt); eerr = 0;
        end
        send_frame(b, bad_par, bad_stop, h, 11);
        tick(10);
        chk({tag, ".kbmat"}, kbmat, mkb);
        chk({tag, ".evt"}, 64'(evt_cnt - e0), 64'(eevt));
        chk({tag, ".err"}, 64'(err_cnt - r0), 64'(eerr));
        chk({tag, ".code"}, 64'(map_code), 64'(mcode));
        chk({tag, ".ext"}, 64'(map_ext), 64'(mcext));
    endtask

    initial begin
        int d, r0, h;
        logic [7:0] b;
        logic [7:0] pool [10];
        logic [7:0] pause_seq [8];
        pool = '{8'h1C, 8'h1C, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hE1, 8'hFA, 8'h00};
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        tick(5);
        chk("rst.kbmat", kbmat, 64'd0);
        chk("rst.code", 64'(map_code), 64'd0);
        chk("rst.ext", 64'(map_ext), 64'd0);
        chk("rst.evt", 64'(kbd_evt), 64'd0);
        chk("rst.err", 64'(rx_err), 64'd0);
        rin = 1'b0;
        tick(50);
        chk("idle.kbmat", kbmat, 64'd0);
        chk("idle.pulses", 64'(evt_cnt + err_cnt), 64'd0);

        send_check(8'h1C, 0, 0, 20, "make1C");
        d = evt_cyc - last_fall;
        chk("latency", 64'(d >= 7 && d <= 9), 64'd1);
        send_check(8'hF0, 0, 0, 20, "brkF0");
        send_check(8'h1C, 0, 0, 20, "brk1C");

        send_check(8'hE0, 0, 0, 18, "extE0");
        send_check(8'h74, 0, 0, 18, "make74");
        send_check(8'hE0, 0, 0, 18, "extE0b");
        send_check(8'hF0, 0, 0, 18, "extF0");
        send_check(8'h74, 0, 0, 18, "brk74");
        send_check(8'h74, 0, 0, 18, "plain74");

        send_check(8'h1C, 1, 0, 20, "badpar");
        send_check(8'hF0, 0, 1, 20, "badstop");
        send_check(8'h1C, 0, 0, 20, "afterr");

        r0 = err_cnt;
        send_frame(8'h1C, 0, 0, 20, 4);
        for (int i = 0; i < TIMEOUT + 50 && err_cnt == r0; i++) tick(1);
        chk("to.err", 64'(err_cnt - r0), 64'd1);
        d = err_cyc - last_fall;
        chk("to.time", 64'(d >= TIMEOUT + 5 && d <= TIMEOUT + 11), 64'd1);
        mbrk = 0; mext = 0; mskip = 0;
        tick(10);
        send_check(8'hF0, 0, 0, 20, "toF0");
        send_check(8'h1C, 0, 0, 20, "to1Cbrk");
        send_check(8'h1C, 0, 0, 20, "to1Cmake");

        for (int i = 0; i < 8; i++) send_check(pause_seq[i], 0, 0, 16, "pause");
        chk("pause.held", 64'(kbmat[45]), 64'd1);
        send_check(8'hAA, 0, 0, 16, "clrAA");
        chk("clr.zero", kbmat, 64'd0);

        r0 = err_cnt;
        ps2_dat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ps2_clk = 1'b0;
            tick($urandom_range(1, FILT_LEN - 1));
            ps2_clk = 1'b1;
            tick(10);
        end
        ps2_dat = 1'b1;
        tick(TIMEOUT + 50);
        chk("glitch.err", 64'(err_cnt - r0), 64'd0);
        send_check(8'h1C, 0, 0, 20, "glitch1C");

        for (int i = 0; i < 40; i++) begin
            h = $urandom_range(12, 25);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
            else                           b = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) send_check(b, 1, 0, h, "rnd.err");
            else                           send_check(b, 0, 0, h, "rnd");
        end

        chk("exclusive", 64'(both_cnt), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
